// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel-load / serial-out handshake bundle.
// master drives the word and load; slave returns the serial stream.
interface piso_tx_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] d_par;
    logic             load;
    logic             ready;
    logic             q_ser;
    logic             q_valid;
    logic             done;

    modport master (
        output d_par, load,
        input  ready, q_ser, q_valid, done
    );

    modport slave (
        input  d_par, load,
        output ready, q_ser, q_valid, done
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, IDLE/SHIFT FSM.
// Outputs decode registered state only; back-to-back words stream gaplessly.
module piso_tx #(
    parameter int WIDTH     = 3,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic     clk,
    input logic     rst,
    piso_tx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign last   = (state == SHIFT) && (cnt == LAST);
    assign accept = bus.load && bus.ready;

    // Output decode from registered state, counter and shift register.
    always_comb begin
        bus.ready   = 1'b1;
        bus.q_valid = 1'b0;
        bus.q_ser   = 1'b0;
        bus.done    = 1'b0;
        if (state == SHIFT) begin
            bus.ready   = last;
            bus.q_valid = 1'b1;
            bus.q_ser   = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
            bus.done    = last;
        end
    end

    // Next-state: accept enters/stays in SHIFT, word end without load idles.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = SHIFT;
            end
            SHIFT: begin
                if (accept)    state_nx = SHIFT;
                else if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath: capture on accept, otherwise shift one bit per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bus.d_par;
            cnt  <= '0;
        end else if (state == SHIFT && !last) begin
            sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
            cnt  <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: vector table for the 3-bit MSB-first instance,
// queue scoreboard for LSB-first and 8-bit instances.
module tb_piso_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(3)) ifm ();
    piso_tx_if #(.WIDTH(3)) ifl ();
    piso_tx_if #(.WIDTH(8)) if8 ();

    piso_tx #(.WIDTH(3), .LSB_FIRST(1'b0)) u_m (
        .clk(clk), .rst(rst), .bus(ifm.slave));
    piso_tx #(.WIDTH(3), .LSB_FIRST(1'b1)) u_l (
        .clk(clk), .rst(rst), .bus(ifl.slave));
    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_8 (
        .clk(clk), .rst(rst), .bus(if8.slave));

    typedef struct {
        string      nm;
        bit         rst;
        bit         load;
        logic [2:0] d;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        logic b;
        logic dn;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   nchk = 0;
    int   nerr = 0;
    int   sel  = 0;

    logic mv, mq, md, mr;

    // Monitor mux onto the instance currently under scoreboard test.
    always_comb begin
        mv = ifl.q_valid;
        mq = ifl.q_ser;
        md = ifl.done;
        mr = ifl.ready;
        if (sel == 1) begin
            mv = if8.q_valid;
            mq = if8.q_ser;
            md = if8.done;
            mr = if8.ready;
        end
    end

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%b want=%b", nm, got, exp);
        end
    endtask

    function automatic void add(input string nm, input bit r, input bit l,
                                input logic [2:0] d, input logic [3:0] e);
        vec_t v;
        v.nm = nm; v.rst = r; v.load = l; v.d = d; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic void push_word(input logic [15:0] d, input int w,
                                      input bit lsb);
        sb_t e;
        for (int i = 0; i < w; i++) begin
            e.b  = lsb ? d[i] : d[w-1-i];
            e.dn = (i == w - 1);
            sbq.push_back(e);
        end
    endfunction

    task automatic drain(input string nm);
        sb_t e;
        int  n = 0;
        while (sbq.size() > 0 && n < 40) begin
            if (mv) begin
                e = sbq.pop_front();
                chk({nm, "_bit"}, {14'd0, mq, md}, {14'd0, e.b, e.dn});
            end
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() > 0) begin
            nerr++;
            nchk++;
            $display("FAIL %s_timeout got=%0d want=0 left", nm, sbq.size());
            sbq.delete();
        end
        chk({nm, "_idle"}, {14'd0, mv, mr}, {14'd0, 1'b0, 1'b1});
    endtask

    initial begin
        ifm.load = 1'b0; ifm.d_par = '0;
        ifl.load = 1'b0; ifl.d_par = '0;
        if8.load = 1'b0; if8.d_par = '0;

        // exp = {ready, q_ser, q_valid, done}
        for (int i = 0; i < 5; i++)
            add("reset", 0, 1, 3'b111, 4'b1000);
        add("single0", 1, 1, 3'b101, 4'b0110);
        add("single1", 1, 0, 3'b101, 4'b0010);
        add("single2", 1, 0, 3'b101, 4'b1111);
        add("single_end", 1, 0, 3'b101, 4'b1000);
        add("b2b0", 1, 1, 3'b110, 4'b0110);
        add("b2b1", 1, 1, 3'b110, 4'b0110);
        add("b2b2", 1, 1, 3'b110, 4'b1011);
        add("b2b3", 1, 1, 3'b011, 4'b0010);
        add("b2b4", 1, 0, 3'b011, 4'b0110);
        add("b2b5", 1, 0, 3'b011, 4'b1111);
        add("b2b_end", 1, 0, 3'b011, 4'b1000);
        add("busy0", 1, 1, 3'b100, 4'b0110);
        add("busy1", 1, 0, 3'b100, 4'b0010);
        add("busy2", 1, 1, 3'b111, 4'b1011);
        add("busy_end", 1, 0, 3'b111, 4'b1000);
        add("rstmid0", 1, 1, 3'b111, 4'b0110);
        add("rstmid1", 1, 0, 3'b111, 4'b0110);
        add("rstmid2", 0, 0, 3'b111, 4'b1000);
        add("rstmid3", 1, 0, 3'b111, 4'b1000);

        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            ifm.load  = tbl[i].load;
            ifm.d_par = tbl[i].d;
            @(posedge clk); #1;
            chk(tbl[i].nm,
                {12'd0, ifm.ready, ifm.q_ser, ifm.q_valid, ifm.done},
                {12'd0, tbl[i].exp});
        end
        ifm.load = 1'b0;
        rst = 1'b1;

        sel = 0;
        ifl.d_par = 3'b110;
        ifl.load  = 1'b1;
        push_word(16'h0006, 3, 1'b1);
        @(posedge clk); #1;
        ifl.load  = 1'b0;
        ifl.d_par = 3'b001;
        drain("lsb");

        sel = 1;
        if8.d_par = 8'hA5;
        if8.load  = 1'b1;
        push_word(16'h00A5, 8, 1'b0);
        @(posedge clk); #1;
        if8.load = 1'b0;
        drain("w8");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 3, number of bits per parallel word (legal range 2..16).
REQ-002 Parameter LSB_FIRST, default 0, serial bit order (0 = MSB first, 1 = LSB first).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 d_par  input  WIDTH  parallel word to serialize.
REQ-006 load  input  1  load request; sampled on rising clk edge.
REQ-007 ready  output  1  block accepts load this cycle.
REQ-008 q_ser  output  1  serial data bit.
REQ-009 q_valid  output  1  q_ser carries a valid data bit this cycle.
REQ-010 done  output  1  one-cycle pulse, high during the last bit of a word.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 The block SHALL hold an internal WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits, range 0..WIDTH-1.
REQ-013 In IDLE: ready=1, q_valid=0, q_ser=0, done=0.
REQ-014 In SHIFT: q_valid=1; q_ser = current output bit of the shift register.
REQ-015 In SHIFT: ready=1 only when counter==WIDTH-1, the last-bit cycle; otherwise ready=0.
REQ-016 In SHIFT: done=1 only when counter==WIDTH-1; all outputs registered or decoded from registered state, with no combinational path from load or d_par.
REQ-017 Accept: load=1 and ready=1 at a rising edge SHALL capture d_par, clear the counter, and enter or stay in SHIFT.
REQ-018 Latency: the first bit of the word SHALL appear on q_ser in the cycle immediately after the accepting edge.
REQ-019 Order: LSB_FIRST=0 emits d_par[WIDTH-1] first, down to d_par[0]; LSB_FIRST=1 emits d_par[0] first, up to d_par[WIDTH-1].
REQ-020 Each edge in SHIFT without accept SHALL shift one bit and increment the counter.
REQ-021 Word end: at the edge ending the last-bit cycle, the FSM SHALL go to IDLE if load=0, or reload and stay in SHIFT if load=1.
REQ-022 Back-to-back words SHALL stream with no idle cycle between them.
REQ-023 load while ready=0 SHALL be ignored, with no effect on data, counter or state; d_par changes after the accept have no effect on the word in flight.
REQ-024 Counter wrap: the counter SHALL never exceed WIDTH-1; it returns to 0 only on accept or reset.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, counter=0, and shift register=0 at that edge, overriding load.
REQ-026 After reset the outputs SHALL be ready=1, q_ser=0, q_valid=0, done=0.
REQ-027 Reset during SHIFT SHALL abort the word with no done pulse; the remaining bits are discarded.
REQ-028 The first accept SHALL be possible at the first edge with rst=1.

Verification (WIDTH=3 unless stated)
REQ-029 Reset: hold rst=0 for 5 cycles with load=1, d_par=3'b111 -> ready=1, q_ser=0, q_valid=0, done=0 throughout.
REQ-030 Single word: pulse load one cycle with d_par=3'b101 -> q_ser 1,0,1 on 3 consecutive cycles, q_valid high for exactly 3 cycles, done high on the 3rd only, then IDLE.
REQ-031 Back-to-back:
- load with 3'b110, keep load=1, switch d_par to 3'b011 during the last-bit cycle.
- Expect q_ser 1,1,0,0,1,1 contiguous, q_valid high for 6 cycles, done high on the 3rd and 6th cycles.
REQ-032 Busy load ignored:
- load 3'b100, then pulse load=1 with d_par=3'b111 during bit index 1 only.
- Expect q_ser 1,0,0, then IDLE with q_valid=0.
REQ-033 Reset mid-word: load 3'b111, drive rst=0 during the 2nd bit -> q_valid=0, ready=1 after that edge; no done pulse.
REQ-034 Order: LSB_FIRST=1, load 3'b110 -> q_ser 0,1,1; WIDTH=8 with 8'hA5 MSB-first -> 1,0,1,0,0,1,0,1, done on the 8th bit.
